// File: rtl/fft_core.sv
// rtl/fft_core.sv - block radix-2 DIT FFT, load / in-place compute / natural-order unload
// Samples land bit-reversed in RAM so the in-place butterflies leave bins in natural order.
module fft_core #(
    parameter int N  = 1024,
    parameter int DW = 32,
    parameter int TW = 18,
    parameter int PW = 11
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          sink_valid,
    output logic          sink_ready,
    input  logic [1:0]    sink_error,
    input  logic          sink_sop,
    input  logic          sink_eop,
    input  logic [DW-1:0] sink_real,
    input  logic [DW-1:0] sink_imag,
    input  logic [PW-1:0] fftpts_in,
    output logic          source_valid,
    input  logic          source_ready,
    output logic [1:0]    source_error,
    output logic          source_sop,
    output logic          source_eop,
    output logic [DW-1:0] source_real,
    output logic [DW-1:0] source_imag,
    output logic [PW-1:0] fftpts_out
);

    localparam int  LOGN = $clog2(N);
    localparam int  PRW  = DW + TW + 1;
    localparam int  SW   = DW + 1;
    localparam real PI   = 3.14159265358979323846;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMPUTE, S_UNLOAD} state_t;

    state_t          r_state;
    logic [DW-1:0]   r_mem_re [0:N-1];
    logic [DW-1:0]   r_mem_im [0:N-1];
    logic [LOGN-1:0] r_cnt;
    logic [LOGN-1:0] r_stage;
    logic [LOGN-2:0] r_bfly;
    logic [LOGN-1:0] r_out_idx;
    logic [1:0]      r_err;
    logic [PW-1:0]   r_pts;
    logic            r_sink_ready;
    logic            r_src_valid;
    logic            r_src_sop;
    logic            r_src_eop;
    logic [1:0]      r_src_err;
    logic [DW-1:0]   r_src_re;
    logic [DW-1:0]   r_src_im;
    logic [PW-1:0]   r_pts_out;

    function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] v);
        logic [LOGN-1:0] r;
        for (int i = 0; i < LOGN; i++) r[i] = v[LOGN-1-i];
        return r;
    endfunction

    // Twiddle ROM: W[k] = round(65536 * exp(-j*2*pi*k/N)), evaluated at elaboration
    logic signed [TW-1:0] w_tw_re [0:N/2-1];
    logic signed [TW-1:0] w_tw_im [0:N/2-1];
    for (genvar gk = 0; gk < N/2; gk++) begin : g_tw
        localparam real ANG = 2.0 * PI * gk / N;
        localparam real CR  = 65536.0 * $cos(ANG);
        localparam real CI  = -65536.0 * $sin(ANG);
        localparam int  CRI = (CR >= 0.0) ? $rtoi(CR + 0.5) : -$rtoi(0.5 - CR);
        localparam int  CII = (CI >= 0.0) ? $rtoi(CI + 0.5) : -$rtoi(0.5 - CI);
        assign w_tw_re[gk] = TW'(CRI);
        assign w_tw_im[gk] = TW'(CII);
    end

    logic            w_beat;
    logic            w_load_we;
    logic [LOGN-1:0] w_load_addr;
    logic [1:0]      w_sop_err;

    assign w_beat      = sink_valid & r_sink_ready;
    assign w_load_we   = w_beat & (sink_sop | (r_state == S_LOAD));
    assign w_load_addr = sink_sop ? '0 : bitrev(r_cnt);
    assign w_sop_err   = sink_error | {fftpts_in != PW'(N), 1'b0};

    // Butterfly j of stage s: a = group*2^(s+1) + pos, b = a + 2^s, twiddle k = pos * N/2^(s+1)
    logic [LOGN-1:0] w_half, w_mask, w_bfly_ext, w_pos, w_a_idx, w_b_idx;
    logic [LOGN-2:0] w_tw_idx;

    assign w_half     = LOGN'(1) << r_stage;
    assign w_mask     = w_half - LOGN'(1);
    assign w_bfly_ext = {1'b0, r_bfly};
    assign w_pos      = w_bfly_ext & w_mask;
    assign w_a_idx    = ((w_bfly_ext & ~w_mask) << 1) | w_pos;
    assign w_b_idx    = w_a_idx | w_half;
    assign w_tw_idx   = (LOGN-1)'(w_pos << (LOGN'(LOGN - 1) - r_stage));

    logic signed [DW-1:0]  w_ar, w_ai, w_br, w_bi;
    logic signed [TW-1:0]  w_wr, w_wi;
    logic signed [PRW-1:0] w_pr, w_pi;
    logic signed [SW-1:0]  w_tr, w_ti;
    logic signed [SW-1:0]  w_sa_r, w_sa_i, w_sb_r, w_sb_i;
    logic [DW-1:0]         w_na_r, w_na_i, w_nb_r, w_nb_i;

    assign w_ar = $signed(r_mem_re[w_a_idx]);
    assign w_ai = $signed(r_mem_im[w_a_idx]);
    assign w_br = $signed(r_mem_re[w_b_idx]);
    assign w_bi = $signed(r_mem_im[w_b_idx]);
    assign w_wr = w_tw_re[w_tw_idx];
    assign w_wi = w_tw_im[w_tw_idx];

    assign w_pr = PRW'(w_br) * PRW'(w_wr) - PRW'(w_bi) * PRW'(w_wi);
    assign w_pi = PRW'(w_br) * PRW'(w_wi) + PRW'(w_bi) * PRW'(w_wr);
    assign w_tr = SW'(w_pr >>> 16);
    assign w_ti = SW'(w_pi >>> 16);

    // One guard bit on the sums, then halve so every stage scales by 1/2
    assign w_sa_r = SW'(w_ar) + w_tr;
    assign w_sa_i = SW'(w_ai) + w_ti;
    assign w_sb_r = SW'(w_ar) - w_tr;
    assign w_sb_i = SW'(w_ai) - w_ti;
    assign w_na_r = DW'(w_sa_r >>> 1);
    assign w_na_i = DW'(w_sa_i >>> 1);
    assign w_nb_r = DW'(w_sb_r >>> 1);
    assign w_nb_i = DW'(w_sb_i >>> 1);

    // Sample RAM holds no state worth resetting; the FSM decides what is valid
    always_ff @(posedge clk) begin
        if (w_load_we) begin
            r_mem_re[w_load_addr] <= sink_real;
            r_mem_im[w_load_addr] <= sink_imag;
        end
        if (r_state == S_COMPUTE) begin
            r_mem_re[w_a_idx] <= w_na_r;
            r_mem_im[w_a_idx] <= w_na_i;
            r_mem_re[w_b_idx] <= w_nb_r;
            r_mem_im[w_b_idx] <= w_nb_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_stage      <= '0;
            r_bfly       <= '0;
            r_out_idx    <= '0;
            r_err        <= '0;
            r_pts        <= '0;
            r_sink_ready <= 1'b1;
            r_src_valid  <= 1'b0;
            r_src_sop    <= 1'b0;
            r_src_eop    <= 1'b0;
            r_src_err    <= '0;
            r_src_re     <= '0;
            r_src_im     <= '0;
            r_pts_out    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_beat && sink_sop) begin
                        r_cnt <= LOGN'(1);
                        r_pts <= fftpts_in;
                        r_err <= w_sop_err;
                        if (!sink_eop) r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_beat) begin
                        if (sink_sop) begin
                            r_cnt <= LOGN'(1);
                            r_pts <= fftpts_in;
                            r_err <= w_sop_err;
                            if (sink_eop) r_state <= S_IDLE;
                        end else if (r_cnt == LOGN'(N - 1)) begin
                            r_err        <= r_err | sink_error | {1'b0, ~sink_eop};
                            r_state      <= S_COMPUTE;
                            r_sink_ready <= 1'b0;
                            r_stage      <= '0;
                            r_bfly       <= '0;
                        end else if (sink_eop) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_cnt <= r_cnt + LOGN'(1);
                            r_err <= r_err | sink_error;
                        end
                    end
                end
                S_COMPUTE: begin
                    r_bfly <= r_bfly + (LOGN-1)'(1);
                    if (r_bfly == '1) begin
                        r_stage <= r_stage + LOGN'(1);
                        if (r_stage == LOGN'(LOGN - 1)) begin
                            r_state   <= S_UNLOAD;
                            r_out_idx <= '0;
                            r_src_err <= r_err;
                            r_pts_out <= r_pts;
                        end
                    end
                end
                S_UNLOAD: begin
                    if (r_src_valid && source_ready && r_src_eop) begin
                        r_state      <= S_IDLE;
                        r_sink_ready <= 1'b1;
                        r_src_valid  <= 1'b0;
                        r_src_sop    <= 1'b0;
                        r_src_eop    <= 1'b0;
                        r_src_err    <= '0;
                        r_src_re     <= '0;
                        r_src_im     <= '0;
                        r_pts_out    <= '0;
                    end else if (!r_src_valid || source_ready) begin
                        r_src_valid <= 1'b1;
                        r_src_re    <= r_mem_re[r_out_idx];
                        r_src_im    <= r_mem_im[r_out_idx];
                        r_src_sop   <= (r_out_idx == '0);
                        r_src_eop   <= (r_out_idx == LOGN'(N - 1));
                        r_out_idx   <= r_out_idx + LOGN'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign sink_ready   = r_sink_ready;
    assign source_valid = r_src_valid;
    assign source_sop   = r_src_sop;
    assign source_eop   = r_src_eop;
    assign source_error = r_src_err;
    assign source_real  = r_src_re;
    assign source_imag  = r_src_im;
    assign fftpts_out   = r_pts_out;

endmodule

// File: tb/tb_fft_core.sv
// tb/tb_fft_core.sv - scoreboard bench for fft_core against a loop-based DFT-scaled reference
module tb_fft_core;

    localparam int N  = 1024;
    localparam int DW = 32;
    localparam int TW = 18;
    localparam int PW = 11;

    logic          clk;
    logic          reset_n;
    logic          sink_valid;
    logic          sink_ready;
    logic [1:0]    sink_error;
    logic          sink_sop;
    logic          sink_eop;
    logic [DW-1:0] sink_real;
    logic [DW-1:0] sink_imag;
    logic [PW-1:0] fftpts_in;
    logic          source_valid;
    logic          source_ready;
    logic [1:0]    source_error;
    logic          source_sop;
    logic          source_eop;
    logic [DW-1:0] source_real;
    logic [DW-1:0] source_imag;
    logic [PW-1:0] fftpts_out;

    fft_core #(.N(N), .DW(DW), .TW(TW), .PW(PW)) dut (
        .clk(clk), .reset_n(reset_n),
        .sink_valid(sink_valid), .sink_ready(sink_ready), .sink_error(sink_error),
        .sink_sop(sink_sop), .sink_eop(sink_eop), .sink_real(sink_real),
        .sink_imag(sink_imag), .fftpts_in(fftpts_in),
        .source_valid(source_valid), .source_ready(source_ready), .source_error(source_error),
        .source_sop(source_sop), .source_eop(source_eop), .source_real(source_real),
        .source_imag(source_imag), .fftpts_out(fftpts_out)
    );

    typedef struct packed {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic          sop;
        logic          eop;
        logic [1:0]    err;
        logic [PW-1:0] pts;
    } exp_t;

    exp_t   sb[$];
    int     n_vec = 0;
    int     n_err = 0;
    int     rdy_mode = 0;
    bit     g_abort = 0;
    longint in_re[N], in_im[N], out_re[N], out_im[N];
    longint tw_re[N/2], tw_im[N/2];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void check(string name, longint act, longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    function automatic longint rnd(real x);
        if (x >= 0.0) return longint'($floor(x + 0.5));
        return -longint'($floor(0.5 - x));
    endfunction

    function automatic int rev(int v);
        int r = 0;
        for (int i = 0; i < $clog2(N); i++) if (v[i]) r |= 1 << ($clog2(N) - 1 - i);
        return r;
    endfunction

    // Reference: textbook iterative DIT with per-stage halving, 64-bit integer arithmetic
    function automatic void run_model();
        longint ar[N], ai[N];
        longint wr, wi, tr, ti, xr, xi, yr, yi;
        int     ia, ib;
        for (int k = 0; k < N; k++) begin
            ar[rev(k)] = in_re[k];
            ai[rev(k)] = in_im[k];
        end
        for (int len = 2; len <= N; len = len * 2)
            for (int base = 0; base < N; base += len)
                for (int j = 0; j < len / 2; j++) begin
                    wr = tw_re[j * (N / len)];
                    wi = tw_im[j * (N / len)];
                    ia = base + j;
                    ib = ia + len / 2;
                    xr = ar[ia]; xi = ai[ia]; yr = ar[ib]; yi = ai[ib];
                    tr = (yr * wr - yi * wi) >>> 16;
                    ti = (yr * wi + yi * wr) >>> 16;
                    ar[ia] = longint'(int'((xr + tr) >>> 1));
                    ai[ia] = longint'(int'((xi + ti) >>> 1));
                    ar[ib] = longint'(int'((xr - tr) >>> 1));
                    ai[ib] = longint'(int'((xi - ti) >>> 1));
                end
        for (int k = 0; k < N; k++) begin
            out_re[k] = ar[k];
            out_im[k] = ai[k];
        end
    endfunction

    function automatic void push_expected(logic [1:0] err, logic [PW-1:0] pts);
        exp_t e;
        for (int k = 0; k < N; k++) begin
            e.re  = DW'(out_re[k]);
            e.im  = DW'(out_im[k]);
            e.sop = (k == 0);
            e.eop = (k == N - 1);
            e.err = err;
            e.pts = pts;
            sb.push_back(e);
        end
    endfunction

    task automatic beat(input bit sop, input bit eop, input longint re, input longint im,
                        input logic [PW-1:0] pts, input logic [1:0] err);
        int guard = 0;
        bit acc = 0;
        if (g_abort) return;
        sink_valid = 1'b1; sink_sop = sop; sink_eop = eop;
        sink_real = DW'(re); sink_imag = DW'(im);
        fftpts_in = pts; sink_error = err;
        while (!acc) begin
            @(negedge clk);
            acc = sink_ready;
            @(posedge clk);
            #1;
            guard++;
            if (!acc && guard > 20000) begin
                n_vec++; n_err++;
                $display("FAIL sink_ready_timeout: got 0, expected 1");
                g_abort = 1;
                break;
            end
        end
        sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0; sink_error = 2'b00;
    endtask

    task automatic send_frame(input int nbeats, input bit eop_last, input logic [PW-1:0] pts,
                              input int err_beat, input logic [1:0] err_val, input bit gaps);
        for (int i = 0; i < nbeats; i++) begin
            if (gaps && $urandom_range(7) == 0) begin
                @(posedge clk);
                #1;
            end
            beat(i == 0, eop_last && (i == nbeats - 1), in_re[i], in_im[i], pts,
                 (i == err_beat) ? err_val : 2'b00);
        end
    endtask

    task automatic wait_drain();
        int g = 0;
        while ((sb.size() != 0 || source_valid) && g < 20000) begin
            @(posedge clk);
            #1;
            g++;
        end
        check("drain_queue_empty", sb.size(), 0);
    endtask

    task automatic set_random();
        for (int i = 0; i < N; i++) begin
            in_re[i] = longint'($urandom_range(0, 1 << 30)) - longint'(1 << 29);
            in_im[i] = longint'($urandom_range(0, 1 << 30)) - longint'(1 << 29);
        end
    endtask

    task automatic set_impulse();
        for (int i = 0; i < N; i++) begin
            in_re[i] = (i == 0) ? longint'(1 << 20) : 0;
            in_im[i] = 0;
        end
    endtask

    function automatic void push_impulse();
        exp_t e;
        for (int k = 0; k < N; k++) begin
            e.re = DW'(1024); e.im = '0; e.sop = (k == 0); e.eop = (k == N - 1);
            e.err = 2'b00; e.pts = PW'(N);
            sb.push_back(e);
        end
    endfunction

    initial begin
        source_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       source_ready = 1'b1;
                1:       source_ready = ~source_ready;
                default: source_ready = ($urandom_range(3) != 0);
            endcase
        end
    end

    // Monitor: pops one expectation per accepted bin, checks hold during stalls
    logic          m_stall = 0;
    logic [DW-1:0] h_re, h_im;
    logic          h_sop, h_eop;
    int            n_pop = 0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && m_stall) begin
                check("stall_hold_re", source_real, h_re);
                check("stall_hold_im", source_imag, h_im);
                check("stall_hold_flags", {source_valid, source_sop, source_eop}, {1'b1, h_sop, h_eop});
            end
            if (source_valid) check("sink_ready_in_unload", sink_ready, 0);
            if (source_valid && source_ready) begin
                if (sb.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_bin: got valid output, expected none");
                end else begin
                    e = sb.pop_front();
                    check($sformatf("bin%0d_re", n_pop % N), longint'($signed(source_real)), longint'($signed(e.re)));
                    check($sformatf("bin%0d_im", n_pop % N), longint'($signed(source_imag)), longint'($signed(e.im)));
                    check("bin_sop", source_sop, e.sop);
                    check("bin_eop", source_eop, e.eop);
                    check("bin_error", source_error, e.err);
                    check("bin_fftpts", fftpts_out, e.pts);
                    n_pop++;
                end
            end
            m_stall = reset_n && source_valid && !source_ready;
            h_re = source_real; h_im = source_imag; h_sop = source_sop; h_eop = source_eop;
        end
    end

    initial begin
        reset_n = 1'b0; sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
        sink_error = 2'b00; sink_real = '0; sink_imag = '0; fftpts_in = PW'(N);
        for (int k = 0; k < N / 2; k++) begin
            tw_re[k] = rnd(65536.0 * $cos(2.0 * 3.14159265358979323846 * k / N));
            tw_im[k] = rnd(-65536.0 * $sin(2.0 * 3.14159265358979323846 * k / N));
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_sink_ready", sink_ready, 1);
        check("rst_source_valid", source_valid, 0);
        check("rst_source_data", {source_real, source_imag}, 0);
        check("rst_source_flags", {source_sop, source_eop, source_error}, 0);
        check("rst_fftpts_out", fftpts_out, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Impulse: every bin exactly 1024 + 0j
        set_impulse();
        send_frame(N, 1, PW'(N), -1, 2'b00, 0);
        push_impulse();
        wait_drain();

        // DC: only bin 0 is non-zero
        for (int i = 0; i < N; i++) begin in_re[i] = 65536; in_im[i] = 0; end
        send_frame(N, 1, PW'(N), -1, 2'b00, 1);
        for (int k = 0; k < N; k++) begin out_re[k] = (k == 0) ? 65536 : 0; out_im[k] = 0; end
        push_expected(2'b00, PW'(N));
        wait_drain();

        // Tone with source_ready toggling every cycle
        for (int i = 0; i < N; i++) begin
            in_re[i] = rnd(16777216.0 * $cos(2.0 * 3.14159265358979323846 * i / N));
            in_im[i] = 0;
        end
        rdy_mode = 1;
        send_frame(N, 1, PW'(N), -1, 2'b00, 0);
        run_model();
        push_expected(2'b00, PW'(N));
        wait_drain();

        // Random data, random backpressure; idle non-sop beats and a restarted frame first
        rdy_mode = 2;
        for (int i = 0; i < 3; i++) beat(0, 0, 77, 88, PW'(N), 2'b11);
        beat(1, 0, 5, 6, PW'(N), 2'b01);
        for (int i = 0; i < 6; i++) beat(0, 0, 9, 9, PW'(N), 2'b01);
        set_random();
        send_frame(N, 1, PW'(N), -1, 2'b00, 1);
        run_model();
        push_expected(2'b00, PW'(N));
        wait_drain();
        rdy_mode = 0;

        // Early eop aborts the frame
        set_random();
        send_frame(11, 1, PW'(N), -1, 2'b00, 0);
        @(negedge clk);
        check("abort_sink_ready", sink_ready, 1);
        repeat (20) @(posedge clk);
        #1 check("abort_no_output", source_valid, 0);

        // No eop on the last beat
        set_random();
        send_frame(N, 0, PW'(N), -1, 2'b00, 1);
        run_model();
        push_expected(2'b01, PW'(N));
        wait_drain();

        // Mismatched fftpts_in
        set_random();
        send_frame(N, 1, PW'(512), -1, 2'b00, 0);
        run_model();
        push_expected(2'b10, PW'(512));
        wait_drain();

        // Upstream error tag on a single beat
        set_random();
        send_frame(N, 1, PW'(N), $urandom_range(1, N - 2), 2'b10, 0);
        run_model();
        push_expected(2'b10, PW'(N));
        wait_drain();

        // Reset asserted during compute discards the frame
        set_impulse();
        send_frame(N, 1, PW'(N), -1, 2'b00, 0);
        repeat (200) @(posedge clk);
        @(negedge clk);
        check("compute_sink_ready", sink_ready, 0);
        @(posedge clk);
        #1 reset_n = 1'b0;
        @(negedge clk);
        check("reset_source_valid", source_valid, 0);
        check("reset_sink_ready", sink_ready, 1);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("post_reset_sink_ready", sink_ready, 1);
        @(posedge clk);
        #1;
        send_frame(N, 1, PW'(N), -1, 2'b00, 0);
        push_impulse();
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
